ghost_motion_ctrl: RTL and testbench
====================================

Name: ghost_motion_ctrl

Overview:
Per-ghost motion controller for the Pac-Man playfield. It holds a fixed-point position and integrates a direction-driven velocity once per frame. Position is clamped to the screen and pushed back on wall collisions. A turn request is buffered until the next frame update, and the block runs a mode machine (NORMAL / FRIGHT / EATEN) with frame-counted timers. It is instantiated once per ghost, between the ghost AI (direction source) and the ghost bitmap/draw logic.

Parameters:
INITIAL_X, 280, spawn top-left X in pixels
INITIAL_Y, 185, spawn top-left Y in pixels
SPEED, 150, NORMAL speed in fixed-point units per frame
FRAC_BITS, 6, fixed-point fraction bits (multiplier 2^FRAC_BITS)
FRIGHT_SHIFT, 1, FRIGHT speed = SPEED >> FRIGHT_SHIFT
OBJ_W, 64, sprite width in pixels
OBJ_H, 64, sprite height in pixels
SCREEN_W, 640, screen width in pixels
SCREEN_H, 480, screen height in pixels
MARGIN, 2, safety margin and collision push-back, in pixels
FRIGHT_FRAMES, 180, frighten duration in frames
BLINK_FRAMES, 60, final FRIGHT frames that assert fright_ending
EATEN_FRAMES, 90, frames frozen after being eaten
POS_W, 11, output coordinate width

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk pulse per frame
collision  in  1  ghost overlaps a wall this cycle
HitEdgeCode  in  4  [3]=left [2]=top [1]=right [0]=bottom edge hit
dir_req  in  2  requested direction: 0 up, 1 down, 2 right, 3 left
dir_req_valid  in  1  dir_req is valid this cycle
frighten  in  1  pulse: enter or restart FRIGHT
eaten  in  1  pulse: pacman ate this ghost
topLeftX  out  POS_W signed  pixel X
topLeftY  out  POS_W signed  pixel Y
move  out  1  velocity non-zero
dir_ghost  out  2  current direction
mode  out  2  0 NORMAL, 1 FRIGHT, 2 EATEN
fright_ending  out  1  FRIGHT and timer < BLINK_FRAMES

Behaviour:
- Clock and reset: one clock, clk. resetN is asynchronous and active-low.
- Reset values: position = INITIAL << FRAC_BITS on both axes; velocity 0; dir 0 (up); pending empty; mode NORMAL; timer 0; state IDLE.
- Reset output values: topLeftX=INITIAL_X, topLeftY=INITIAL_Y, move=0, dir_ghost=0, mode=0, fright_ending=0.
- Arithmetic widths: internal position and velocity are signed, POS_W+FRAC_BITS+1 bits.
- Output conversion: topLeft = position >>> FRAC_BITS. Outputs are registered-state derived, so there is no combinational path from inputs.
- Speed selection: cur_speed = SPEED in NORMAL, SPEED>>FRIGHT_SHIFT in FRIGHT, 0 in EATEN.
- Direction to velocity: up/down give (0, ∓cur_speed); right/left give (±cur_speed, 0).
- Pending turn buffer: dir_req_valid overwrites the 1-entry pending register. The last request before a frame update wins.
- Opposite-direction request: applied immediately (dir and velocity updated the next cycle), and pending is cleared.

FSM states and transitions:
- IDLE: on startOfFrame, go to MOVE.
- MOVE, on collision: for each set HitEdgeCode bit, push the position back by MARGIN<<FRAC_BITS away from that edge.
  - Zero the velocity component along the current dir, set blocked=1, and go to WAIT_EOF.
- MOVE, on startOfFrame: go to POS_CHANGE.
- MOVE, collision and startOfFrame in the same cycle: the push-back is applied and the next state is POS_CHANGE.
- WAIT_EOF: on startOfFrame, go to POS_CHANGE. Collisions in this state are ignored.
- POS_CHANGE: if pending is valid, load dir from pending, clear pending and clear blocked.
  - If not blocked, velocity is recomputed from dir and cur_speed.
  - Position += velocity (uses the velocity computed in this same state).
  - Timer logic runs here. Then go to LIMITS.
- LIMITS: clamp X to [MARGIN, SCREEN_W-1-MARGIN-OBJ_W]<<FRAC_BITS and Y to [MARGIN, SCREEN_H-1-MARGIN-OBJ_H]<<FRAC_BITS.
  - On a clamp, zero that axis velocity and set blocked. Ghosts do not bounce.
  - Then go to MOVE.

Mode machine:
- frighten in NORMAL or FRIGHT: mode=FRIGHT, timer=FRIGHT_FRAMES, and dir reverses (an opposite turn).
- eaten in FRIGHT: mode=EATEN, timer=EATEN_FRAMES, velocity 0. eaten in NORMAL or EATEN is ignored.
- frighten in EATEN is ignored.
- frighten and eaten in the same cycle: eaten wins if mode is FRIGHT.
- Timer: in POS_CHANGE with mode≠NORMAL, the timer decrements.
  - Timer reaching 0 in FRIGHT: mode=NORMAL.
  - Timer reaching 0 in EATEN: position = spawn, dir=up, blocked=0, pending cleared, mode=NORMAL.
- move = (Xvel≠0 || Yvel≠0). dir_ghost = dir register.
- Reset mid-frame: returns to IDLE immediately, and the remainder of the frame is discarded.

Decomposition:
- ghost_pkg: dir_t enum {UP, DOWN, RIGHT, LEFT}, mode_t enum {NORMAL, FRIGHT, EATEN}, FSM state enum, and a function opposite(dir_t).
- Sub-module ghost_mode_timer: mode register, frame down-counter, and fright_ending. Inputs: frighten, eaten, tick (POS_CHANGE strobe). Outputs: mode, respawn pulse, reverse pulse.

Test Plan:
1. Reset, then dir_req=right (valid), then 5 startOfFrame pulses. Frame 1 only leaves IDLE; frames 2–5 each add 150 to X, giving 17920+600=18520. Required: topLeftX=289, topLeftY=185, move=1, dir_ghost=2.
2. Moving right, assert frighten. Required: dir_ghost=3 next cycle and mode=1. After 4 frames X decreases by 4*75=300. fright_ending rises when timer=59; mode=0 after 180 frames.
3. In FRIGHT, eaten and frighten asserted in the same cycle. Required: mode=2 and move=0. After 90 frames: topLeftX=280, topLeftY=185, dir_ghost=0, mode=0.
4. Moving right, collision with HitEdgeCode=4'b0010. Required: X decreases by 128 (2<<6) and move=0. Then dir_req=down plus startOfFrame: Y increases by 150 and move=1.
5. Drive right to the edge. Required: X clamps to 573<<6, topLeftX=573, move=0, with no bounce.
6. Two dir_req pulses (down, then up) within one frame while moving left. Required: only up is applied at the next POS_CHANGE, Y decreases by 150.

Source files
------------

// File: rtl/ghost_pkg.sv
// ghost_pkg - shared types for the ghost motion controller.
//   dir_t   : movement direction, encoded as the ghost AI drives dir_req
//   mode_t  : ghost behaviour mode
//   state_t : frame-sequencing FSM states
//   opposite(): returns the reverse of a direction
package ghost_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        RIGHT = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FRIGHT = 2'd1,
        EATEN  = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MOVE       = 3'd1,
        S_WAIT_EOF   = 3'd2,
        S_POS_CHANGE = 3'd3,
        S_LIMITS     = 3'd4
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            RIGHT:   return LEFT;
            default: return RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/ghost_motion_ctrl_if.sv
// ghost_motion_ctrl_if - signals between the ghost AI / playfield logic and
// one ghost motion controller.
//   master : frame strobe, wall collision info, direction requests, mode events
//            (driven), position / direction / mode (observed)
//   slave  : the motion controller side
interface ghost_motion_ctrl_if #(
    parameter int POS_W = 11
);
    logic                    startOfFrame;
    logic                    collision;
    logic [3:0]              HitEdgeCode;
    logic [1:0]              dir_req;
    logic                    dir_req_valid;
    logic                    frighten;
    logic                    eaten;
    logic signed [POS_W-1:0] topLeftX;
    logic signed [POS_W-1:0] topLeftY;
    logic                    move;
    logic [1:0]              dir_ghost;
    logic [1:0]              mode;
    logic                    fright_ending;

    modport master (
        output startOfFrame, collision, HitEdgeCode, dir_req, dir_req_valid,
               frighten, eaten,
        input  topLeftX, topLeftY, move, dir_ghost, mode, fright_ending
    );

    modport slave (
        input  startOfFrame, collision, HitEdgeCode, dir_req, dir_req_valid,
               frighten, eaten,
        output topLeftX, topLeftY, move, dir_ghost, mode, fright_ending
    );
endinterface

// File: rtl/ghost_mode_timer.sv
// ghost_mode_timer - NORMAL / FRIGHT / EATEN mode register with a frame
// down-counter.
//   clk, resetN   : clock, async active-low reset
//   frighten      : enter or restart FRIGHT (ignored while EATEN)
//   eaten         : enter EATEN (only honoured while FRIGHT, beats frighten)
//   tick          : one strobe per frame update
//   mode          : current mode
//   respawn       : same-cycle strobe, EATEN timer expires on this tick
//   reverse       : same-cycle strobe, accepted frighten forces a U-turn
//   fright_ending : FRIGHT with fewer than BLINK_FRAMES frames left
module ghost_mode_timer
    import ghost_pkg::*;
#(
    parameter int FRIGHT_FRAMES = 180,
    parameter int BLINK_FRAMES  = 60,
    parameter int EATEN_FRAMES  = 90
) (
    input  logic  clk,
    input  logic  resetN,
    input  logic  frighten,
    input  logic  eaten,
    input  logic  tick,
    output mode_t mode,
    output logic  respawn,
    output logic  reverse,
    output logic  fright_ending
);
    localparam int MAX_FRAMES = (FRIGHT_FRAMES > EATEN_FRAMES) ? FRIGHT_FRAMES : EATEN_FRAMES;
    localparam int TW = $clog2(MAX_FRAMES + 1);
    localparam logic [TW-1:0] FRIGHT_T = TW'(FRIGHT_FRAMES);
    localparam logic [TW-1:0] EATEN_T  = TW'(EATEN_FRAMES);
    localparam logic [TW-1:0] BLINK_T  = TW'(BLINK_FRAMES);

    logic [TW-1:0] timer;
    logic          eat_ok;
    logic          last_tick;

    assign eat_ok    = eaten && (mode == FRIGHT);
    assign reverse   = frighten && (mode != EATEN) && !eat_ok;
    // timer == 1 on a tick means it reaches zero with this frame
    assign last_tick = tick && (mode != NORMAL) && (timer <= TW'(1));
    assign respawn   = last_tick && (mode == EATEN);
    assign fright_ending = (mode == FRIGHT) && (timer < BLINK_T);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mode  <= NORMAL;
            timer <= '0;
        end else if (eat_ok) begin
            mode  <= EATEN;
            timer <= EATEN_T;
        end else if (reverse) begin
            mode  <= FRIGHT;
            timer <= FRIGHT_T;
        end else if (tick && (mode != NORMAL)) begin
            timer <= timer - 1'b1;
            if (last_tick) begin
                mode <= NORMAL;
            end
        end
    end

endmodule

// File: rtl/ghost_motion_ctrl.sv
// ghost_motion_ctrl - per-ghost fixed-point motion controller.
//   clk, resetN : clock, async active-low reset
//   bus (slave) : startOfFrame, collision/HitEdgeCode, dir_req(_valid),
//                 frighten, eaten in; topLeftX/Y, move, dir_ghost, mode,
//                 fright_ending out (all from registered state)
//
// state        | meaning
// S_IDLE       | after reset, waiting for the first frame strobe
// S_MOVE       | frame in progress, watching for wall collisions
// S_WAIT_EOF   | collision handled, ignoring further hits until next frame
// S_POS_CHANGE | apply pending turn, recompute velocity, integrate position
// S_LIMITS     | clamp position to the screen area
module ghost_motion_ctrl
    import ghost_pkg::*;
#(
    parameter int INITIAL_X     = 280,
    parameter int INITIAL_Y     = 185,
    parameter int SPEED         = 150,
    parameter int FRAC_BITS     = 6,
    parameter int FRIGHT_SHIFT  = 1,
    parameter int OBJ_W         = 64,
    parameter int OBJ_H         = 64,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int MARGIN        = 2,
    parameter int FRIGHT_FRAMES = 180,
    parameter int BLINK_FRAMES  = 60,
    parameter int EATEN_FRAMES  = 90,
    parameter int POS_W         = 11
) (
    input  logic               clk,
    input  logic               resetN,
    ghost_motion_ctrl_if.slave bus
);
    localparam int VW = POS_W + FRAC_BITS + 1;

    localparam logic signed [VW-1:0] SPAWN_X = VW'(INITIAL_X << FRAC_BITS);
    localparam logic signed [VW-1:0] SPAWN_Y = VW'(INITIAL_Y << FRAC_BITS);
    localparam logic signed [VW-1:0] SPD_N   = VW'(SPEED);
    localparam logic signed [VW-1:0] SPD_F   = VW'(SPEED >> FRIGHT_SHIFT);
    localparam logic signed [VW-1:0] PUSH    = VW'(MARGIN << FRAC_BITS);
    localparam logic signed [VW-1:0] X_MIN   = VW'(MARGIN << FRAC_BITS);
    localparam logic signed [VW-1:0] X_MAX   = VW'((SCREEN_W - 1 - MARGIN - OBJ_W) << FRAC_BITS);
    localparam logic signed [VW-1:0] Y_MIN   = VW'(MARGIN << FRAC_BITS);
    localparam logic signed [VW-1:0] Y_MAX   = VW'((SCREEN_H - 1 - MARGIN - OBJ_H) << FRAC_BITS);

    function automatic logic signed [VW-1:0] vx_of(input dir_t d, input logic signed [VW-1:0] s);
        case (d)
            RIGHT:   return s;
            LEFT:    return -s;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [VW-1:0] vy_of(input dir_t d, input logic signed [VW-1:0] s);
        case (d)
            DOWN:    return s;
            UP:      return -s;
            default: return '0;
        endcase
    endfunction

    state_t state, state_nx;
    logic signed [VW-1:0] pos_x, pos_y, vel_x, vel_y;
    logic signed [VW-1:0] pos_x_nx, pos_y_nx, vel_x_nx, vel_y_nx;
    logic signed [VW-1:0] vx_eff, vy_eff, cur_speed;
    dir_t  dir, dir_nx, dir_eff, pend_dir, pend_dir_nx, dreq;
    logic  pend_valid, pend_valid_nx, blocked, blocked_nx, blk_eff;
    mode_t mode;
    logic  tick, respawn, reverse, fright_ending;

    assign tick = (state == S_POS_CHANGE);
    assign dreq = dir_t'(bus.dir_req);

    ghost_mode_timer #(
        .FRIGHT_FRAMES (FRIGHT_FRAMES),
        .BLINK_FRAMES  (BLINK_FRAMES),
        .EATEN_FRAMES  (EATEN_FRAMES)
    ) u_mode_timer (
        .clk           (clk),
        .resetN        (resetN),
        .frighten      (bus.frighten),
        .eaten         (bus.eaten),
        .tick          (tick),
        .mode          (mode),
        .respawn       (respawn),
        .reverse       (reverse),
        .fright_ending (fright_ending)
    );

    always_comb begin
        case (mode)
            NORMAL:  cur_speed = SPD_N;
            FRIGHT:  cur_speed = SPD_F;
            default: cur_speed = '0;
        endcase
    end

    always_comb begin
        state_nx      = state;
        pos_x_nx      = pos_x;
        pos_y_nx      = pos_y;
        vel_x_nx      = vel_x;
        vel_y_nx      = vel_y;
        dir_nx        = dir;
        pend_valid_nx = pend_valid;
        pend_dir_nx   = pend_dir;
        blocked_nx    = blocked;
        dir_eff       = dir;
        blk_eff       = blocked;
        vx_eff        = vel_x;
        vy_eff        = vel_y;

        case (state)
            S_IDLE: begin
                if (bus.startOfFrame) state_nx = S_MOVE;
            end
            S_MOVE: begin
                if (bus.collision) begin
                    // push away from every edge that was hit
                    if (bus.HitEdgeCode[3]) pos_x_nx = pos_x_nx + PUSH;
                    if (bus.HitEdgeCode[2]) pos_y_nx = pos_y_nx + PUSH;
                    if (bus.HitEdgeCode[1]) pos_x_nx = pos_x_nx - PUSH;
                    if (bus.HitEdgeCode[0]) pos_y_nx = pos_y_nx - PUSH;
                    if ((dir == UP) || (dir == DOWN)) vel_y_nx = '0;
                    else                              vel_x_nx = '0;
                    blocked_nx = 1'b1;
                    state_nx   = bus.startOfFrame ? S_POS_CHANGE : S_WAIT_EOF;
                end else if (bus.startOfFrame) begin
                    state_nx = S_POS_CHANGE;
                end
            end
            S_WAIT_EOF: begin
                if (bus.startOfFrame) state_nx = S_POS_CHANGE;
            end
            S_POS_CHANGE: begin
                if (pend_valid) begin
                    dir_eff       = pend_dir;
                    blk_eff       = 1'b0;
                    pend_valid_nx = 1'b0;
                end
                if (!blk_eff) begin
                    vx_eff = vx_of(dir_eff, cur_speed);
                    vy_eff = vy_of(dir_eff, cur_speed);
                end
                dir_nx     = dir_eff;
                blocked_nx = blk_eff;
                vel_x_nx   = vx_eff;
                vel_y_nx   = vy_eff;
                pos_x_nx   = pos_x + vx_eff;
                pos_y_nx   = pos_y + vy_eff;
                if (respawn) begin
                    pos_x_nx      = SPAWN_X;
                    pos_y_nx      = SPAWN_Y;
                    dir_nx        = UP;
                    blocked_nx    = 1'b0;
                    pend_valid_nx = 1'b0;
                end
                state_nx = S_LIMITS;
            end
            S_LIMITS: begin
                if (pos_x < X_MIN) begin
                    pos_x_nx = X_MIN; vel_x_nx = '0; blocked_nx = 1'b1;
                end else if (pos_x > X_MAX) begin
                    pos_x_nx = X_MAX; vel_x_nx = '0; blocked_nx = 1'b1;
                end
                if (pos_y < Y_MIN) begin
                    pos_y_nx = Y_MIN; vel_y_nx = '0; blocked_nx = 1'b1;
                end else if (pos_y > Y_MAX) begin
                    pos_y_nx = Y_MAX; vel_y_nx = '0; blocked_nx = 1'b1;
                end
                state_nx = S_MOVE;
            end
            default: state_nx = S_IDLE;
        endcase

        // frighten U-turn already runs at FRIGHT speed, mode catches up next cycle
        if (reverse) begin
            dir_nx        = opposite(dir_nx);
            vel_x_nx      = vx_of(dir_nx, SPD_F);
            vel_y_nx      = vy_of(dir_nx, SPD_F);
            pend_valid_nx = 1'b0;
        end

        if (bus.dir_req_valid) begin
            if (dreq == opposite(dir_nx)) begin
                dir_nx        = dreq;
                vel_x_nx      = vx_of(dreq, cur_speed);
                vel_y_nx      = vy_of(dreq, cur_speed);
                pend_valid_nx = 1'b0;
            end else begin
                pend_valid_nx = 1'b1;
                pend_dir_nx   = dreq;
            end
        end

        if (mode == EATEN) begin
            vel_x_nx = '0;
            vel_y_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_IDLE;
            pos_x      <= SPAWN_X;
            pos_y      <= SPAWN_Y;
            vel_x      <= '0;
            vel_y      <= '0;
            dir        <= UP;
            pend_valid <= 1'b0;
            pend_dir   <= UP;
            blocked    <= 1'b0;
        end else begin
            state      <= state_nx;
            pos_x      <= pos_x_nx;
            pos_y      <= pos_y_nx;
            vel_x      <= vel_x_nx;
            vel_y      <= vel_y_nx;
            dir        <= dir_nx;
            pend_valid <= pend_valid_nx;
            pend_dir   <= pend_dir_nx;
            blocked    <= blocked_nx;
        end
    end

    // arithmetic shift then truncate to POS_W is exactly this slice
    assign bus.topLeftX      = pos_x[FRAC_BITS +: POS_W];
    assign bus.topLeftY      = pos_y[FRAC_BITS +: POS_W];
    assign bus.move          = (vel_x != '0) || (vel_y != '0);
    assign bus.dir_ghost     = dir;
    assign bus.mode          = mode;
    assign bus.fright_ending = fright_ending;

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
module tb_ghost_motion_ctrl;

    typedef struct {
        int x;
        int y;
        int mv;
        int dir;
        int md;
        int fe;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic chk_req = 1'b0;
    int   total = 0;
    int   bad = 0;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;

    ghost_motion_ctrl_if #(.POS_W(11)) bus ();

    ghost_motion_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        if (req < 0) return;
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    // monitor: pops one expectation per sample strobe
    always @(negedge clk) begin
        if (chk_req) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                cmp(mon_n, "topLeftX", int'(bus.topLeftX), mon_e.x);
                cmp(mon_n, "topLeftY", int'(bus.topLeftY), mon_e.y);
                cmp(mon_n, "move", int'(bus.move), mon_e.mv);
                cmp(mon_n, "dir_ghost", int'(bus.dir_ghost), mon_e.dir);
                cmp(mon_n, "mode", int'(bus.mode), mon_e.md);
                cmp(mon_n, "fright_ending", int'(bus.fright_ending), mon_e.fe);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input int x, input int y, input int mv,
                              input int d, input int md, input int fe);
        exp_t e;
        e.x = x; e.y = y; e.mv = mv; e.dir = d; e.md = md; e.fe = fe;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_req = 1'b1;
        step();
        chk_req = 1'b0;
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            bus.startOfFrame = 1'b1;
            step();
            bus.startOfFrame = 1'b0;
            repeat (5) step();
        end
    endtask

    task automatic frame_req(input logic [1:0] d);
        bus.dir_req = d;
        bus.dir_req_valid = 1'b1;
        bus.startOfFrame = 1'b1;
        step();
        bus.dir_req_valid = 1'b0;
        bus.startOfFrame = 1'b0;
        repeat (5) step();
    endtask

    task automatic req(input logic [1:0] d);
        bus.dir_req = d;
        bus.dir_req_valid = 1'b1;
        step();
        bus.dir_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.startOfFrame = 0; bus.collision = 0; bus.HitEdgeCode = 4'b0;
        bus.dir_req = 2'd0; bus.dir_req_valid = 0; bus.frighten = 0; bus.eaten = 0;
        repeat (3) step();
        resetN = 1'b1;
        expect_out("reset", 280, 185, 0, 0, 0, 0);

        // 1: pending right, first frame only leaves IDLE, then 4 x 150
        req(2'd2);
        frame(5);
        expect_out("t1_move_right", 289, 185, 1, 2, 0, 0);

        // 2: frighten reverses and halves speed
        bus.frighten = 1'b1; step(); bus.frighten = 1'b0;
        expect_out("t2_reverse", 289, 185, 1, 3, 1, 0);
        frame(4);
        expect_out("t2_4frames", 284, 185, 1, 3, 1, 0);
        frame(116);
        expect_out("t2_timer60", 148, 185, 1, 3, 1, 0);
        frame(1);
        expect_out("t2_timer59", 147, 185, 1, 3, 1, 1);
        frame(58);
        expect_out("t2_timer1", 79, 185, 1, 3, 1, 1);
        frame(1);
        expect_out("t2_expire", 78, 185, 1, 3, 0, 0);

        // 3: frighten, then eaten+frighten together -> EATEN
        bus.frighten = 1'b1; step(); bus.frighten = 1'b0;
        bus.frighten = 1'b1; bus.eaten = 1'b1; step();
        bus.frighten = 1'b0; bus.eaten = 1'b0;
        step();
        expect_out("t3_eaten", 78, 185, 0, 2, 2, 0);
        bus.frighten = 1'b1; step(); bus.frighten = 1'b0;
        expect_out("t3_fright_ignored", 78, 185, 0, 2, 2, 0);
        frame(89);
        expect_out("t3_89frames", 78, 185, 0, 2, 2, 0);
        frame(1);
        expect_out("t3_respawn", 280, 185, 0, 0, 0, 0);

        // 4: collision on the right edge, then turn down
        req(2'd2);
        frame(1);
        expect_out("t4_right", 282, 185, 1, 2, 0, 0);
        bus.collision = 1'b1; bus.HitEdgeCode = 4'b0010; step();
        bus.collision = 1'b0; bus.HitEdgeCode = 4'b0000;
        expect_out("t4_pushback", 280, 185, 0, 2, 0, 0);
        frame_req(2'd1);
        expect_out("t4_down", 280, 187, 1, 1, 0, 0);

        // 5: run into the right clamp, no bounce
        req(2'd2);
        frame(130);
        expect_out("t5_clamp", 573, 187, 0, 2, 0, 0);
        frame(3);
        expect_out("t5_no_bounce", 573, 187, 0, 2, 0, 0);

        // 6: opposite turn is immediate; last of two pending requests wins
        req(2'd3);
        expect_out("t6_opposite", 573, 187, 1, 3, 0, 0);
        frame(1);
        expect_out("t6_left", 570, 187, 1, 3, 0, 0);
        req(2'd1);
        req(2'd0);
        frame(1);
        expect_out("t6_last_wins", 570, 185, 1, 0, 0, 0);

        // eaten outside FRIGHT is ignored
        bus.eaten = 1'b1; step(); bus.eaten = 1'b0;
        step();
        expect_out("eaten_in_normal", 570, 185, 1, 0, 0, 0);

        // reset in the middle of a frame
        bus.startOfFrame = 1'b1; step(); bus.startOfFrame = 1'b0;
        resetN = 1'b0;
        expect_out("midframe_reset", 280, 185, 0, 0, 0, 0);
        resetN = 1'b1;
        req(2'd2);
        frame(1);
        expect_out("idle_first_frame", 280, 185, 0, 0, 0, 0);
        frame(1);
        expect_out("after_idle", 282, 185, 1, 2, 0, 0);

        repeat (2) step();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
